surf_wb_router: RTL and testbench

//  Upstream stage of the SURF bridge: accepts one host-side classic WISHBONE target port and turns it

---
 rtl/surf_bridge_pkg.sv | 20 ++
 rtl/wb_timeout_ctr.sv | 33 +++
 rtl/surf_wb_router.sv | 190 +++++++++++++++++++
 tb/tb_surf_wb_router.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/surf_bridge_pkg.sv
// Shared definitions for the SURF bridge front end.
//   router_state_t : router FSM states
//   term_t         : host-side termination kind delivered in RESP
//   surf_sel_valid : true for a SURF select that addresses a populated slot (1..NUM_SURF)
package surf_bridge_pkg;

  localparam int SURF_SEL_LSB = 25;
  localparam int SURF_SEL_W   = 3;
  localparam int SURF_ADR_W   = 25;
  localparam int NUM_SURF     = 7;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP, RESP} router_state_t;

  typedef enum logic [1:0] {T_ACK, T_ERR, T_RTY} term_t;

  function automatic logic surf_sel_valid(input logic [SURF_SEL_W-1:0] sel);
    return (sel != '0) && (int'(sel) <= NUM_SURF);
  endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Clear/enable/expire cycle counter.
//   clk_i, rst_n_i : clock, async active-low reset
//   clr_i          : synchronous clear to 0 (dominates en_i)
//   en_i           : count one per cycle while high
//   expire_o       : high while the count equals TIMEOUT_CYCLES-1 (count holds there)
module wb_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expire_o) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/surf_wb_router.sv
// Host-side WISHBONE target to registered SURF bridge master, with SURF select decode,
// bounded re-issue on bridge retry and a response timeout.
//   wb_clk_i, wb_rst_n_i           : clock, async active-low reset
//   s_cyc_i/s_stb_i/s_we_i/s_sel_i : host request; s_adr_i[27:25] = SURF select, [24:0] = local address
//   s_dat_i / s_dat_o              : host write data / registered read data
//   s_ack_o/s_err_o/s_rty_o        : one-cycle host terminations
//   m_cyc_o/m_stb_o/m_we_o/m_sel_o/m_adr_o/m_dat_o : latched request to the bridge
//   m_dat_i, m_ack_i/m_err_i/m_rty_i : bridge response
//   m_select_o                     : SURF select, stable from accept through RESP
//   busy_o                         : transaction in flight (any state but IDLE)
//   timeout_cnt_o                  : saturating timeout count
module surf_wb_router
  import surf_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned RETRY_GAP      = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        s_cyc_i,
  input  logic        s_stb_i,
  input  logic        s_we_i,
  input  logic [3:0]  s_sel_i,
  input  logic [27:0] s_adr_i,
  input  logic [31:0] s_dat_i,
  output logic [31:0] s_dat_o,
  output logic        s_ack_o,
  output logic        s_err_o,
  output logic        s_rty_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic [24:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i,
  input  logic        m_err_i,
  input  logic        m_rty_i,
  output logic [2:0]  m_select_o,
  output logic        busy_o,
  output logic [15:0] timeout_cnt_o
);

  localparam int unsigned RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  router_state_t   state_q, state_d;
  term_t           term_q, term_d;
  logic            we_q, we_d;
  logic [3:0]      sel_q, sel_d;
  logic [24:0]     adr_q, adr_d;
  logic [31:0]     dat_q, dat_d;
  logic [2:0]      select_q, select_d;
  logic [31:0]     rdat_q, rdat_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [15:0]     tmo_cnt_q, tmo_cnt_d;
  logic            tmo_expire, gap_expire;
  logic [2:0]      req_select;

  assign req_select = s_adr_i[SURF_SEL_LSB +: SURF_SEL_W];

  // Counters are held at zero outside their state, so each entry starts a fresh count.
  wb_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_resp_tmr (
    .clk_i    (wb_clk_i),
    .rst_n_i  (wb_rst_n_i),
    .clr_i    (state_q != ISSUE),
    .en_i     (state_q == ISSUE),
    .expire_o (tmo_expire)
  );

  wb_timeout_ctr #(.TIMEOUT_CYCLES(RETRY_GAP)) u_gap_tmr (
    .clk_i    (wb_clk_i),
    .rst_n_i  (wb_rst_n_i),
    .clr_i    (state_q != GAP),
    .en_i     (state_q == GAP),
    .expire_o (gap_expire)
  );

  always_comb begin
    state_d   = state_q;
    term_d    = term_q;
    we_d      = we_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    select_d  = select_q;
    rdat_d    = rdat_q;
    retry_d   = retry_q;
    tmo_cnt_d = tmo_cnt_q;
    case (state_q)
      IDLE: begin
        if (s_cyc_i && s_stb_i) begin
          we_d     = s_we_i;
          sel_d    = s_sel_i;
          adr_d    = s_adr_i[SURF_ADR_W-1:0];
          dat_d    = s_dat_i;
          select_d = req_select;
          retry_d  = '0;
          if (surf_sel_valid(req_select)) begin
            state_d = ISSUE;
          end else begin
            state_d = RESP;
            term_d  = T_ERR;
          end
        end
      end
      ISSUE: begin
        // A host abort outranks any bridge response: nobody is left to hear it.
        if (!s_cyc_i) begin
          state_d = IDLE;
        end else if (m_ack_i) begin
          state_d = RESP;
          term_d  = T_ACK;
          if (!we_q) rdat_d = m_dat_i;
        end else if (m_err_i) begin
          state_d = RESP;
          term_d  = T_ERR;
        end else if (m_rty_i) begin
          if (retry_q < RETRY_MAX) begin
            state_d = GAP;
            retry_d = retry_q + RW'(1);
          end else begin
            state_d = RESP;
            term_d  = T_RTY;
          end
        end else if (tmo_expire) begin
          state_d = RESP;
          term_d  = T_ERR;
          if (tmo_cnt_q != 16'hFFFF) tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end
      GAP: begin
        if (!s_cyc_i) begin
          state_d = IDLE;
        end else if (gap_expire) begin
          state_d = ISSUE;
        end
      end
      RESP: begin
        state_d = IDLE;
        retry_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q   <= IDLE;
      term_q    <= T_ACK;
      we_q      <= 1'b0;
      sel_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      select_q  <= '0;
      rdat_q    <= '0;
      retry_q   <= '0;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      term_q    <= term_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      select_q  <= select_d;
      rdat_q    <= rdat_d;
      retry_q   <= retry_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // All outputs are decodes of registers, so none depend combinationally on inputs.
  assign m_cyc_o       = (state_q == ISSUE);
  assign m_stb_o       = (state_q == ISSUE);
  assign m_we_o        = we_q;
  assign m_sel_o       = sel_q;
  assign m_adr_o       = adr_q;
  assign m_dat_o       = dat_q;
  assign m_select_o    = select_q;
  assign s_dat_o       = rdat_q;
  assign s_ack_o       = (state_q == RESP) && (term_q == T_ACK);
  assign s_err_o       = (state_q == RESP) && (term_q == T_ERR);
  assign s_rty_o       = (state_q == RESP) && (term_q == T_RTY);
  assign busy_o        = (state_q != IDLE);
  assign timeout_cnt_o = tmo_cnt_q;

endmodule

// File: tb/tb_surf_wb_router.sv
module tb_surf_wb_router;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_n_i;
  logic        s_cyc_i, s_stb_i, s_we_i;
  logic [3:0]  s_sel_i;
  logic [27:0] s_adr_i;
  logic [31:0] s_dat_i, s_dat_o;
  logic        s_ack_o, s_err_o, s_rty_o;
  logic        m_cyc_o, m_stb_o, m_we_o;
  logic [3:0]  m_sel_o;
  logic [24:0] m_adr_o;
  logic [31:0] m_dat_o, m_dat_i;
  logic        m_ack_i, m_err_i, m_rty_i;
  logic [2:0]  m_select_o;
  logic        busy_o;
  logic [15:0] timeout_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  surf_wb_router #(.TIMEOUT_CYCLES(16), .MAX_RETRY(3), .RETRY_GAP(4)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
    .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i), .s_sel_i(s_sel_i),
    .s_adr_i(s_adr_i), .s_dat_i(s_dat_i), .s_dat_o(s_dat_o),
    .s_ack_o(s_ack_o), .s_err_o(s_err_o), .s_rty_o(s_rty_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i),
    .m_ack_i(m_ack_i), .m_err_i(m_err_i), .m_rty_i(m_rty_i),
    .m_select_o(m_select_o), .busy_o(busy_o), .timeout_cnt_o(timeout_cnt_o)
  );

  task automatic cyc();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic host_req(input logic we, input logic [27:0] adr, input logic [31:0] dat);
    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = we; s_sel_i = 4'hF; s_adr_i = adr; s_dat_i = dat;
  endtask

  task automatic host_idle();
    s_cyc_i = 1'b0; s_stb_i = 1'b0;
  endtask

  task automatic test_reset();
    wb_rst_n_i = 1'b0;
    host_idle(); s_we_i = 0; s_sel_i = 0; s_adr_i = 0; s_dat_i = 0;
    m_dat_i = 0; m_ack_i = 0; m_err_i = 0; m_rty_i = 0;
    cyc(); cyc();
    checks++;
    if ({s_dat_o, s_ack_o, s_err_o, s_rty_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o,
         m_dat_o, m_select_o, busy_o, timeout_cnt_o} !== 119'd0) begin
      errors++; $display("FAIL reset_outputs: some output nonzero, m_cyc=%b busy=%b", m_cyc_o, busy_o);
    end
    wb_rst_n_i = 1'b1;
    cyc();
  endtask

  task automatic test_read_ack();
    host_req(1'b0, 28'h2000010, 32'h0);
    cyc();
    checks++;
    if ({m_cyc_o, m_stb_o, busy_o} !== 3'b111) begin
      errors++; $display("FAIL rd_mcyc: got %b expected 111", {m_cyc_o, m_stb_o, busy_o});
    end
    checks++;
    if (m_select_o !== 3'd1 || m_adr_o !== 25'h10) begin
      errors++; $display("FAIL rd_decode: select %0d adr %h expected 1 / 10", m_select_o, m_adr_o);
    end
    repeat (4) cyc();
    m_ack_i = 1'b1; m_dat_i = 32'hCAFEF00D;
    checks++;
    if (s_ack_o !== 1'b0) begin errors++; $display("FAIL rd_early_ack: got %b expected 0", s_ack_o); end
    cyc();
    m_ack_i = 1'b0; m_dat_i = 32'h0;
    checks++;
    if (s_ack_o !== 1'b1 || s_err_o !== 1'b0 || s_rty_o !== 1'b0 || m_cyc_o !== 1'b0) begin
      errors++; $display("FAIL rd_ack: ack %b err %b rty %b mcyc %b expected 1 0 0 0", s_ack_o, s_err_o, s_rty_o, m_cyc_o);
    end
    checks++;
    if (s_dat_o !== 32'hCAFEF00D || m_select_o !== 3'd1) begin
      errors++; $display("FAIL rd_data: dat %h select %0d expected CAFEF00D / 1", s_dat_o, m_select_o);
    end
    host_idle();
    cyc();
    checks++;
    if (s_ack_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL rd_end: ack %b busy %b expected 0 0", s_ack_o, busy_o);
    end
  endtask

  task automatic test_select_zero();
    host_req(1'b1, 28'h0000004, 32'h11223344);
    checks++;
    if (s_err_o !== 1'b0) begin errors++; $display("FAIL sel0_early_err: got %b expected 0", s_err_o); end
    cyc();
    checks++;
    if (s_err_o !== 1'b1 || s_ack_o !== 1'b0 || m_cyc_o !== 1'b0) begin
      errors++; $display("FAIL sel0_err: err %b ack %b mcyc %b expected 1 0 0", s_err_o, s_ack_o, m_cyc_o);
    end
    host_idle();
    cyc();
    checks++;
    if (s_err_o !== 1'b0 || m_cyc_o !== 1'b0) begin
      errors++; $display("FAIL sel0_end: err %b mcyc %b expected 0 0", s_err_o, m_cyc_o);
    end
  endtask

  task automatic test_retry();
    int n;
    host_req(1'b0, 28'h6000020, 32'h0);
    cyc();
    for (int r = 0; r < 3; r++) begin
      m_rty_i = 1'b1;
      cyc();
      m_rty_i = 1'b0;
      checks++;
      if (m_cyc_o !== 1'b0 || s_rty_o !== 1'b0 || m_select_o !== 3'd3) begin
        errors++; $display("FAIL rty_gap_start%0d: mcyc %b srty %b select %0d expected 0 0 3", r, m_cyc_o, s_rty_o, m_select_o);
      end
      n = 0;
      while (m_cyc_o !== 1'b1 && n < 20) begin n++; cyc(); end
      checks++;
      if (n !== 4) begin errors++; $display("FAIL rty_gap_len%0d: got %0d expected 4", r, n); end
    end
    m_ack_i = 1'b1; m_dat_i = 32'h0BADBEEF;
    cyc();
    m_ack_i = 1'b0;
    checks++;
    if (s_ack_o !== 1'b1 || s_rty_o !== 1'b0 || s_dat_o !== 32'h0BADBEEF) begin
      errors++; $display("FAIL rty_then_ack: ack %b rty %b dat %h expected 1 0 0BADBEEF", s_ack_o, s_rty_o, s_dat_o);
    end
    host_idle();
    cyc();
    host_req(1'b0, 28'h6000020, 32'h0);
    cyc();
    for (int r = 0; r < 4; r++) begin
      m_rty_i = 1'b1;
      cyc();
      m_rty_i = 1'b0;
      if (r < 3) begin
        n = 0;
        while (m_cyc_o !== 1'b1 && n < 20) begin n++; cyc(); end
      end
    end
    checks++;
    if (s_rty_o !== 1'b1 || s_ack_o !== 1'b0 || s_err_o !== 1'b0 || m_cyc_o !== 1'b0) begin
      errors++; $display("FAIL rty_exhaust: rty %b ack %b err %b mcyc %b expected 1 0 0 0", s_rty_o, s_ack_o, s_err_o, m_cyc_o);
    end
    host_idle();
    cyc();
  endtask

  task automatic test_timeout();
    int n;
    host_req(1'b0, 28'h4000000, 32'h0);
    cyc();
    n = 0;
    while (m_cyc_o === 1'b1 && n < 40) begin n++; cyc(); end
    checks++;
    if (n !== 16) begin errors++; $display("FAIL tmo_len: got %0d expected 16", n); end
    checks++;
    if (s_err_o !== 1'b1 || timeout_cnt_o !== 16'd1) begin
      errors++; $display("FAIL tmo_err: err %b cnt %0d expected 1 / 1", s_err_o, timeout_cnt_o);
    end
    host_idle();
    cyc();
    host_req(1'b0, 28'h4000000, 32'h0);
    cyc();
    repeat (15) cyc();
    checks++;
    if (m_cyc_o !== 1'b1) begin errors++; $display("FAIL tmo_edge_mcyc: got %b expected 1", m_cyc_o); end
    m_ack_i = 1'b1; m_dat_i = 32'h55AA55AA;
    cyc();
    m_ack_i = 1'b0;
    checks++;
    if (s_ack_o !== 1'b1 || s_err_o !== 1'b0 || timeout_cnt_o !== 16'd1) begin
      errors++; $display("FAIL tmo_ack_wins: ack %b err %b cnt %0d expected 1 0 1", s_ack_o, s_err_o, timeout_cnt_o);
    end
    host_idle();
    cyc();
  endtask

  task automatic test_abort_back_to_back();
    host_req(1'b0, 28'hA000000, 32'h0);
    cyc();
    m_rty_i = 1'b1;
    cyc();
    m_rty_i = 1'b0;
    host_idle();
    for (int i = 0; i < 6; i++) begin
      cyc();
      checks++;
      if ({m_cyc_o, s_ack_o, s_err_o, s_rty_o, busy_o} !== 5'b0) begin
        errors++; $display("FAIL abort_quiet%0d: mcyc/ack/err/rty/busy %b expected 00000", i, {m_cyc_o, s_ack_o, s_err_o, s_rty_o, busy_o});
      end
    end
    m_ack_i = 1'b1;
    cyc();
    m_ack_i = 1'b0;
    checks++;
    if (s_ack_o !== 1'b0 || m_cyc_o !== 1'b0) begin
      errors++; $display("FAIL late_ack: ack %b mcyc %b expected 0 0", s_ack_o, m_cyc_o);
    end
    host_req(1'b0, 28'hE000100, 32'h0);
    cyc();
    checks++;
    if (m_cyc_o !== 1'b1 || m_select_o !== 3'd7 || m_adr_o !== 25'h100) begin
      errors++; $display("FAIL b2b_issue: mcyc %b select %0d adr %h expected 1 7 100", m_cyc_o, m_select_o, m_adr_o);
    end
    m_ack_i = 1'b1; m_dat_i = 32'h12345678;
    cyc();
    m_ack_i = 1'b0;
    checks++;
    if (s_ack_o !== 1'b1 || s_dat_o !== 32'h12345678) begin
      errors++; $display("FAIL b2b_ack: ack %b dat %h expected 1 12345678", s_ack_o, s_dat_o);
    end
    host_idle();
    cyc();
  endtask

  task automatic test_async_reset();
    host_req(1'b1, 28'h8000040, 32'hDEADBEEF);
    cyc();
    checks++;
    if (m_cyc_o !== 1'b1 || m_select_o !== 3'd4 || m_dat_o !== 32'hDEADBEEF) begin
      errors++; $display("FAIL prerst_issue: mcyc %b select %0d dat %h expected 1 4 DEADBEEF", m_cyc_o, m_select_o, m_dat_o);
    end
    #2 wb_rst_n_i = 1'b0;
    #1;
    checks++;
    if ({s_dat_o, s_ack_o, s_err_o, s_rty_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o,
         m_dat_o, m_select_o, busy_o, timeout_cnt_o} !== 119'd0) begin
      errors++; $display("FAIL async_rst: mcyc %b select %0d cnt %0d sdat %h expected all 0", m_cyc_o, m_select_o, timeout_cnt_o, s_dat_o);
    end
    host_idle();
    #2 wb_rst_n_i = 1'b1;
    cyc();
    host_req(1'b0, 28'hC000008, 32'h0);
    cyc();
    checks++;
    if (m_cyc_o !== 1'b1 || m_select_o !== 3'd6 || m_adr_o !== 25'h8) begin
      errors++; $display("FAIL postrst_issue: mcyc %b select %0d adr %h expected 1 6 8", m_cyc_o, m_select_o, m_adr_o);
    end
    m_ack_i = 1'b1; m_dat_i = 32'hA5A5_0001;
    cyc();
    m_ack_i = 1'b0;
    checks++;
    if (s_ack_o !== 1'b1 || s_dat_o !== 32'hA5A5_0001 || m_select_o !== 3'd6) begin
      errors++; $display("FAIL postrst_ack: ack %b dat %h select %0d expected 1 A5A50001 6", s_ack_o, s_dat_o, m_select_o);
    end
    host_idle();
    cyc();
  endtask

  initial begin
    test_reset();
    test_read_ack();
    test_select_zero();
    test_retry();
    test_timeout();
    test_abort_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
